// File: rtl/espacc_dma_rd_arbiter_if.sv
// Bus bundle for the two-client DMA read arbiter: client request/beat channels
// and the shared accelerator DMA read control/data channels.
interface espacc_dma_rd_arbiter_if #(
   parameter int DMA_BUS_WIDTH = 64,
   parameter int LEN_WIDTH     = 32
);
   logic                     c0_rd_ctrl_valid;
   logic                     c0_rd_ctrl_ready;
   logic [31:0]              c0_rd_ctrl_index;
   logic [LEN_WIDTH-1:0]     c0_rd_ctrl_length;
   logic [2:0]               c0_rd_ctrl_size;
   logic                     c0_rd_chnl_valid;
   logic                     c0_rd_chnl_ready;
   logic [DMA_BUS_WIDTH-1:0] c0_rd_chnl_data;

   logic                     c1_rd_ctrl_valid;
   logic                     c1_rd_ctrl_ready;
   logic [31:0]              c1_rd_ctrl_index;
   logic [LEN_WIDTH-1:0]     c1_rd_ctrl_length;
   logic [2:0]               c1_rd_ctrl_size;
   logic                     c1_rd_chnl_valid;
   logic                     c1_rd_chnl_ready;
   logic [DMA_BUS_WIDTH-1:0] c1_rd_chnl_data;

   logic                     dma_read_ctrl_valid;
   logic                     dma_read_ctrl_ready;
   logic [31:0]              dma_read_ctrl_data_index;
   logic [LEN_WIDTH-1:0]     dma_read_ctrl_data_length;
   logic [2:0]               dma_read_ctrl_data_size;
   logic                     dma_read_chnl_valid;
   logic                     dma_read_chnl_ready;
   logic [DMA_BUS_WIDTH-1:0] dma_read_chnl_data;

   // arbiter side
   modport slave (
      input  c0_rd_ctrl_valid, c0_rd_ctrl_index, c0_rd_ctrl_length, c0_rd_ctrl_size, c0_rd_chnl_ready,
      output c0_rd_ctrl_ready, c0_rd_chnl_valid, c0_rd_chnl_data,
      input  c1_rd_ctrl_valid, c1_rd_ctrl_index, c1_rd_ctrl_length, c1_rd_ctrl_size, c1_rd_chnl_ready,
      output c1_rd_ctrl_ready, c1_rd_chnl_valid, c1_rd_chnl_data,
      output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
             dma_read_ctrl_data_size, dma_read_chnl_ready,
      input  dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data
   );

   // requester/DMA environment side
   modport master (
      output c0_rd_ctrl_valid, c0_rd_ctrl_index, c0_rd_ctrl_length, c0_rd_ctrl_size, c0_rd_chnl_ready,
      input  c0_rd_ctrl_ready, c0_rd_chnl_valid, c0_rd_chnl_data,
      output c1_rd_ctrl_valid, c1_rd_ctrl_index, c1_rd_ctrl_length, c1_rd_ctrl_size, c1_rd_chnl_ready,
      input  c1_rd_ctrl_ready, c1_rd_chnl_valid, c1_rd_chnl_data,
      input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
             dma_read_ctrl_data_size, dma_read_chnl_ready,
      output dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data
   );
endinterface

// File: rtl/espacc_dma_rd_arbiter.sv
// Round-robin arbiter sharing one ESP DMA read path (ctrl + data) between two
// clients; each grant spans the ctrl handshake plus exactly `length` beats.
module espacc_dma_rd_arbiter_port (
   input  logic grant_en,
   input  logic win_sel,
   input  logic data_en,
   input  logic own_sel,
   input  logic dma_valid,
   output logic ctrl_ready,
   output logic chnl_valid
);
   assign ctrl_ready = grant_en & win_sel;
   assign chnl_valid = data_en & own_sel & dma_valid;
endmodule

module espacc_dma_rd_arbiter #(
   parameter int DMA_BUS_WIDTH = 64,
   parameter int LEN_WIDTH     = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   espacc_dma_rd_arbiter_if.slave bus,
   output logic                   busy,
   output logic                   owner
);
   localparam int NUM_CLIENTS = 2;

   typedef enum logic [1:0] {IDLE, CTRL, DATA} state_t;

   state_t state_q, state_d;

   logic [NUM_CLIENTS-1:0]                req_valid;
   logic [NUM_CLIENTS-1:0][31:0]          req_index;
   logic [NUM_CLIENTS-1:0][LEN_WIDTH-1:0] req_length;
   logic [NUM_CLIENTS-1:0][2:0]           req_size;
   logic [NUM_CLIENTS-1:0]                cl_chnl_ready;
   logic [NUM_CLIENTS-1:0]                cl_ctrl_ready;
   logic [NUM_CLIENTS-1:0]                cl_chnl_valid;
   logic [NUM_CLIENTS-1:0]                win_oh, own_oh;

   logic                     rr_last, winner, grant, ctrl_hs, beat_hs, last_beat;
   logic                     data_phase;
   logic [31:0]              index_q;
   logic [LEN_WIDTH-1:0]     length_q, beats_left;
   logic [2:0]               size_q;
   logic [DMA_BUS_WIDTH-1:0] rd_data;

   assign req_valid     = {bus.c1_rd_ctrl_valid,  bus.c0_rd_ctrl_valid};
   assign req_index     = {bus.c1_rd_ctrl_index,  bus.c0_rd_ctrl_index};
   assign req_length    = {bus.c1_rd_ctrl_length, bus.c0_rd_ctrl_length};
   assign req_size      = {bus.c1_rd_ctrl_size,   bus.c0_rd_ctrl_size};
   assign cl_chnl_ready = {bus.c1_rd_chnl_ready,  bus.c0_rd_chnl_ready};

   // tie goes to the client that did not win last; rr_last resets to 1 so c0 wins first
   assign winner = (&req_valid) ? ~rr_last : req_valid[1];
   assign win_oh = winner ? 2'b10 : 2'b01;
   assign own_oh = owner  ? 2'b10 : 2'b01;

   // rst gates the grant so ctrl_ready reads 0 the moment reset is asserted
   assign grant      = (state_q == IDLE) && (|req_valid) && rst;
   assign ctrl_hs    = (state_q == CTRL) && bus.dma_read_ctrl_ready;
   assign data_phase = (state_q == DATA);
   assign beat_hs    = data_phase && bus.dma_read_chnl_valid && cl_chnl_ready[owner];
   assign last_beat  = beat_hs && (beats_left == {{(LEN_WIDTH-1){1'b0}}, 1'b1});

   for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_port
      espacc_dma_rd_arbiter_port u_port (
         .grant_en   (grant),
         .win_sel    (win_oh[i]),
         .data_en    (data_phase),
         .own_sel    (own_oh[i]),
         .dma_valid  (bus.dma_read_chnl_valid),
         .ctrl_ready (cl_ctrl_ready[i]),
         .chnl_valid (cl_chnl_valid[i])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d                 = state_q;
      bus.dma_read_ctrl_valid = 1'b0;
      bus.dma_read_chnl_ready = 1'b0;
      case (state_q)
         IDLE: if (grant) state_d = CTRL;
         CTRL: begin
            bus.dma_read_ctrl_valid = 1'b1;
            if (bus.dma_read_ctrl_ready)
               state_d = (length_q == '0) ? IDLE : DATA;
         end
         DATA: begin
            bus.dma_read_chnl_ready = cl_chnl_ready[owner];
            if (last_beat) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         index_q    <= '0;
         length_q   <= '0;
         size_q     <= '0;
         owner      <= 1'b0;
         rr_last    <= 1'b1;
         beats_left <= '0;
      end else begin
         if (grant) begin
            index_q  <= req_index[winner];
            length_q <= req_length[winner];
            size_q   <= req_size[winner];
            owner    <= winner;
            rr_last  <= winner;
         end
         if (ctrl_hs && (length_q != '0))
            beats_left <= length_q;
         else if (beat_hs)
            beats_left <= beats_left - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   assign rd_data = bus.dma_read_chnl_data;

   assign busy                          = (state_q != IDLE);
   assign bus.c0_rd_ctrl_ready          = cl_ctrl_ready[0];
   assign bus.c1_rd_ctrl_ready          = cl_ctrl_ready[1];
   assign bus.c0_rd_chnl_valid          = cl_chnl_valid[0];
   assign bus.c1_rd_chnl_valid          = cl_chnl_valid[1];
   assign bus.c0_rd_chnl_data           = rd_data;
   assign bus.c1_rd_chnl_data           = rd_data;
   assign bus.dma_read_ctrl_data_index  = index_q;
   assign bus.dma_read_ctrl_data_length = length_q;
   assign bus.dma_read_ctrl_data_size   = size_q;
endmodule

// File: tb/tb_espacc_dma_rd_arbiter.sv
// Scoreboard bench for the two-client DMA read arbiter: expected ctrl requests and
// beats are queued as stimulus is driven and matched when the DUT hands them over.
module tb_espacc_dma_rd_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic busy, owner;

   espacc_dma_rd_arbiter_if bus();

   espacc_dma_rd_arbiter dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus.slave),
      .busy  (busy),
      .owner (owner)
   );

   always #5 clk = ~clk;

   typedef struct { logic cid; logic [63:0] data; } beat_t;
   typedef struct { logic cid; logic [31:0] idx; logic [31:0] len; logic [2:0] size; } req_t;

   beat_t beat_q[$];
   req_t  req_q[$];
   int    total = 0;
   int    pass  = 0;
   req_t  mon_r;
   beat_t mon_b;

   // scoreboard consumer: ctrl handshakes and client beats complete on the next rising edge
   always @(negedge clk) begin
      if (bus.dma_read_ctrl_valid && bus.dma_read_ctrl_ready) begin
         total++;
         if (req_q.size() == 0)
            $display("FAIL ctrl_unexpected: got index %h, required no request", bus.dma_read_ctrl_data_index);
         else begin
            mon_r = req_q.pop_front();
            if ({owner, bus.dma_read_ctrl_data_index, bus.dma_read_ctrl_data_length, bus.dma_read_ctrl_data_size}
                !== {mon_r.cid, mon_r.idx, mon_r.len, mon_r.size})
               $display("FAIL ctrl_req: got owner %0d idx %h len %0d size %0d, required owner %0d idx %h len %0d size %0d",
                        owner, bus.dma_read_ctrl_data_index, bus.dma_read_ctrl_data_length, bus.dma_read_ctrl_data_size,
                        mon_r.cid, mon_r.idx, mon_r.len, mon_r.size);
            else pass++;
         end
      end
      if (bus.c0_rd_chnl_valid && bus.c0_rd_chnl_ready) begin
         total++;
         if (beat_q.size() == 0) $display("FAIL c0_beat_unexpected: got %h, required none", bus.c0_rd_chnl_data);
         else begin
            mon_b = beat_q.pop_front();
            if ({1'b0, bus.c0_rd_chnl_data} !== {mon_b.cid, mon_b.data})
               $display("FAIL c0_beat: got c0 data %h, required c%0d data %h", bus.c0_rd_chnl_data, mon_b.cid, mon_b.data);
            else pass++;
         end
      end
      if (bus.c1_rd_chnl_valid && bus.c1_rd_chnl_ready) begin
         total++;
         if (beat_q.size() == 0) $display("FAIL c1_beat_unexpected: got %h, required none", bus.c1_rd_chnl_data);
         else begin
            mon_b = beat_q.pop_front();
            if ({1'b1, bus.c1_rd_chnl_data} !== {mon_b.cid, mon_b.data})
               $display("FAIL c1_beat: got c1 data %h, required c%0d data %h", bus.c1_rd_chnl_data, mon_b.cid, mon_b.data);
            else pass++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", pass, total);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic client_set(input bit cid, input logic v, input logic [31:0] idx,
                             input logic [31:0] len, input logic [2:0] sz);
      if (cid == 1'b0) begin
         bus.c0_rd_ctrl_valid = v; bus.c0_rd_ctrl_index = idx;
         bus.c0_rd_ctrl_length = len; bus.c0_rd_ctrl_size = sz;
      end else begin
         bus.c1_rd_ctrl_valid = v; bus.c1_rd_ctrl_index = idx;
         bus.c1_rd_ctrl_length = len; bus.c1_rd_ctrl_size = sz;
      end
   endtask

   // returns at the negedge where a ctrl_ready is seen; caller ticks through the handshake
   task automatic wait_grant(output int cid, output bit ok);
      ok = 1'b0; cid = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.c0_rd_ctrl_ready) begin cid = 0; ok = 1'b1; break; end
         if (bus.c1_rd_ctrl_ready) begin cid = 1; ok = 1'b1; break; end
         tick();
      end
   endtask

   task automatic client_req(input bit cid, input logic [31:0] idx, input logic [31:0] len,
                             input logic [2:0] sz, output bit ok);
      int g; bit gok;
      req_q.push_back('{cid, idx, len, sz});
      client_set(cid, 1'b1, idx, len, sz);
      wait_grant(g, gok);
      ok = gok && (g == int'(cid));
      tick();
      client_set(cid, 1'b0, idx, len, sz);
   endtask

   task automatic dma_send(input bit cid, input logic [63:0] base, input int n, output bit ok);
      ok = 1'b1;
      for (int k = 0; k < n; k++) begin
         bit got;
         got = 1'b0;
         bus.dma_read_chnl_valid = 1'b1;
         bus.dma_read_chnl_data  = base + 64'(k);
         beat_q.push_back('{cid, base + 64'(k)});
         for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.dma_read_chnl_ready) begin got = 1'b1; break; end
            tick();
         end
         if (!got) ok = 1'b0;
         tick();
      end
      bus.dma_read_chnl_valid = 1'b0;
      bus.dma_read_chnl_data  = '0;
   endtask

   task automatic test_reset();
      bus.c0_rd_ctrl_valid = 1'b1; bus.c1_rd_ctrl_valid = 1'b1;
      bus.dma_read_chnl_valid = 1'b1; bus.dma_read_chnl_data = '0;
      @(negedge clk);
      total++;
      if ({bus.dma_read_ctrl_valid, bus.c0_rd_ctrl_ready, bus.c1_rd_ctrl_ready, busy, owner,
           bus.dma_read_chnl_ready, bus.c0_rd_chnl_valid, bus.c1_rd_chnl_valid} !== 8'b0)
         $display("FAIL reset_ctl: got %b, required 00000000", {bus.dma_read_ctrl_valid, bus.c0_rd_ctrl_ready,
                  bus.c1_rd_ctrl_ready, busy, owner, bus.dma_read_chnl_ready, bus.c0_rd_chnl_valid, bus.c1_rd_chnl_valid});
      else pass++;
      total++;
      if ({bus.dma_read_ctrl_data_index, bus.dma_read_ctrl_data_length, bus.dma_read_ctrl_data_size} !== 67'b0)
         $display("FAIL reset_fields: got idx %h len %h size %h, required 0", bus.dma_read_ctrl_data_index,
                  bus.dma_read_ctrl_data_length, bus.dma_read_ctrl_data_size);
      else pass++;
      total++;
      if (bus.c0_rd_chnl_data !== 64'h0) $display("FAIL reset_data: got %h, required 0", bus.c0_rd_chnl_data);
      else pass++;
      tick();
      bus.c0_rd_ctrl_valid = 1'b0; bus.c1_rd_ctrl_valid = 1'b0; bus.dma_read_chnl_valid = 1'b0;
      rst = 1'b1;
      tick();
   endtask

   task automatic test_round_robin();
      int exp_cid[4] = '{0, 1, 0, 1};
      int g; bit ok;
      req_q.push_back('{1'b0, 32'h1000, 32'd2, 3'd3});
      req_q.push_back('{1'b1, 32'h2000, 32'd2, 3'd3});
      req_q.push_back('{1'b0, 32'h1010, 32'd2, 3'd3});
      req_q.push_back('{1'b1, 32'h2010, 32'd2, 3'd3});
      client_set(1'b0, 1'b1, 32'h1000, 32'd2, 3'd3);
      client_set(1'b1, 1'b1, 32'h2000, 32'd2, 3'd3);
      for (int n = 0; n < 4; n++) begin
         wait_grant(g, ok);
         total++;
         if (!ok || g != exp_cid[n]) $display("FAIL rr_grant%0d: got c%0d, required c%0d", n, g, exp_cid[n]);
         else pass++;
         tick();
         client_set(g[0], n < 2, (g[0] ? 32'h2000 : 32'h1000) + 32'h10, 32'd2, 3'd3);
         dma_send(g[0], 64'h100 * 64'(n + 1), 2, ok);
         total++;
         if (!ok) $display("FAIL rr_data%0d: got beat timeout, required 2 beats", n);
         else pass++;
         total++;
         if (owner !== 1'(exp_cid[n])) $display("FAIL rr_owner%0d: got %0d, required %0d", n, owner, exp_cid[n]);
         else pass++;
      end
   endtask

   task automatic test_single();
      bit ok;
      req_q.push_back('{1'b0, 32'h100, 32'd4, 3'd3});
      client_set(1'b0, 1'b1, 32'h100, 32'd4, 3'd3);
      @(negedge clk);
      total++;
      if ({bus.c0_rd_ctrl_ready, bus.c1_rd_ctrl_ready, bus.dma_read_ctrl_valid} !== 3'b100)
         $display("FAIL single_grant: got c0rdy %b c1rdy %b dmav %b, required 1 0 0",
                  bus.c0_rd_ctrl_ready, bus.c1_rd_ctrl_ready, bus.dma_read_ctrl_valid);
      else pass++;
      tick();
      client_set(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
      @(negedge clk);
      total++;
      if ({bus.dma_read_ctrl_valid, bus.dma_read_ctrl_data_index, bus.dma_read_ctrl_data_length, busy}
          !== {1'b1, 32'h100, 32'd4, 1'b1})
         $display("FAIL single_ctrl: got v %b idx %h len %0d busy %b, required 1 100 4 1", bus.dma_read_ctrl_valid,
                  bus.dma_read_ctrl_data_index, bus.dma_read_ctrl_data_length, busy);
      else pass++;
      tick();
      dma_send(1'b0, 64'hD0, 4, ok);
      total++;
      if (!ok) $display("FAIL single_data: got beat timeout, required 4 beats");
      else pass++;
      total++;
      if (busy !== 1'b0) $display("FAIL single_release: got busy %b, required 0", busy);
      else pass++;
   endtask

   task automatic test_backpressure();
      bit ok;
      client_req(1'b1, 32'h200, 32'd4, 3'd3, ok);
      total++;
      if (!ok) $display("FAIL bp_grant: got no c1 grant, required grant");
      else pass++;
      dma_send(1'b1, 64'hA, 1, ok);
      bus.dma_read_chnl_valid = 1'b1; bus.dma_read_chnl_data = 64'hB;
      beat_q.push_back('{1'b1, 64'hB});
      bus.c1_rd_chnl_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if ({bus.dma_read_chnl_ready, bus.c1_rd_chnl_valid, bus.c0_rd_chnl_valid, bus.c1_rd_chnl_data}
             !== {1'b0, 1'b1, 1'b0, 64'hB})
            $display("FAIL bp_stall%0d: got dmardy %b c1v %b c0v %b data %h, required 0 1 0 b", i,
                     bus.dma_read_chnl_ready, bus.c1_rd_chnl_valid, bus.c0_rd_chnl_valid, bus.c1_rd_chnl_data);
         else pass++;
         tick();
      end
      bus.c1_rd_chnl_ready = 1'b1;
      @(negedge clk);
      total++;
      if (bus.dma_read_chnl_ready !== 1'b1) $display("FAIL bp_resume: got dmardy %b, required 1", bus.dma_read_chnl_ready);
      else pass++;
      tick();
      dma_send(1'b1, 64'hC, 1, ok);
      total++;
      if (busy !== 1'b1) $display("FAIL bp_busy_mid: got busy %b, required 1", busy);
      else pass++;
      dma_send(1'b1, 64'hD, 1, ok);
      total++;
      if (!ok || busy !== 1'b0) $display("FAIL bp_release: got ok %b busy %b, required 1 0", ok, busy);
      else pass++;
   endtask

   task automatic test_zero_len();
      bit ok;
      client_req(1'b0, 32'h500, 32'd0, 3'd1, ok);
      bus.dma_read_chnl_valid = 1'b1; bus.dma_read_chnl_data = 64'h55;
      @(negedge clk);
      total++;
      if (!ok || {bus.dma_read_ctrl_valid, bus.dma_read_chnl_ready, bus.c0_rd_chnl_valid} !== 3'b100)
         $display("FAIL zl_ctrl: got ok %b dmav %b dmardy %b c0v %b, required 1 1 0 0", ok,
                  bus.dma_read_ctrl_valid, bus.dma_read_chnl_ready, bus.c0_rd_chnl_valid);
      else pass++;
      tick();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if ({busy, bus.dma_read_chnl_ready, bus.c0_rd_chnl_valid, bus.c1_rd_chnl_valid} !== 4'b0)
            $display("FAIL zl_idle%0d: got busy %b dmardy %b c0v %b c1v %b, required 0 0 0 0", i, busy,
                     bus.dma_read_chnl_ready, bus.c0_rd_chnl_valid, bus.c1_rd_chnl_valid);
         else pass++;
         tick();
      end
      bus.dma_read_chnl_valid = 1'b0; bus.dma_read_chnl_data = '0;
   endtask

   task automatic test_ctrl_stall();
      bit ok; int g;
      bus.dma_read_ctrl_ready = 1'b0;
      client_req(1'b0, 32'h300, 32'd1, 3'd2, ok);
      req_q.push_back('{1'b1, 32'h600, 32'd1, 3'd1});
      client_set(1'b1, 1'b1, 32'h600, 32'd1, 3'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if ({bus.dma_read_ctrl_valid, bus.dma_read_ctrl_data_index, bus.dma_read_ctrl_data_length,
              bus.dma_read_ctrl_data_size, bus.c1_rd_ctrl_ready, bus.c0_rd_ctrl_ready}
             !== {1'b1, 32'h300, 32'd1, 3'd2, 1'b0, 1'b0})
            $display("FAIL stall_hold%0d: got v %b idx %h len %0d size %0d c1rdy %b c0rdy %b, required 1 300 1 2 0 0",
                     i, bus.dma_read_ctrl_valid, bus.dma_read_ctrl_data_index, bus.dma_read_ctrl_data_length,
                     bus.dma_read_ctrl_data_size, bus.c1_rd_ctrl_ready, bus.c0_rd_ctrl_ready);
         else pass++;
         tick();
      end
      bus.dma_read_ctrl_ready = 1'b1;
      dma_send(1'b0, 64'hE0, 1, ok);
      wait_grant(g, ok);
      total++;
      if (!ok || g != 1) $display("FAIL stall_next: got c%0d, required c1", g);
      else pass++;
      tick();
      client_set(1'b1, 1'b0, 32'h600, 32'd1, 3'd1);
      dma_send(1'b1, 64'hF0, 1, ok);
   endtask

   task automatic test_reset_mid_data();
      bit ok; int g;
      client_req(1'b0, 32'h400, 32'd8, 3'd3, ok);
      dma_send(1'b0, 64'h10, 2, ok);
      bus.dma_read_chnl_valid = 1'b1; bus.dma_read_chnl_data = '0;
      bus.c0_rd_ctrl_valid = 1'b1; bus.c1_rd_ctrl_valid = 1'b1;
      rst = 1'b0;
      #1;
      total++;
      if ({bus.dma_read_ctrl_valid, bus.c0_rd_ctrl_ready, bus.c1_rd_ctrl_ready, busy, owner,
           bus.dma_read_chnl_ready, bus.c0_rd_chnl_valid, bus.c1_rd_chnl_valid} !== 8'b0)
         $display("FAIL rst_mid_ctl: got %b, required 00000000", {bus.dma_read_ctrl_valid, bus.c0_rd_ctrl_ready,
                  bus.c1_rd_ctrl_ready, busy, owner, bus.dma_read_chnl_ready, bus.c0_rd_chnl_valid, bus.c1_rd_chnl_valid});
      else pass++;
      total++;
      if ({bus.dma_read_ctrl_data_index, bus.dma_read_ctrl_data_length, bus.dma_read_ctrl_data_size} !== 67'b0)
         $display("FAIL rst_mid_fields: got idx %h len %h, required 0", bus.dma_read_ctrl_data_index,
                  bus.dma_read_ctrl_data_length);
      else pass++;
      tick();
      bus.dma_read_chnl_valid = 1'b0;
      req_q.push_back('{1'b0, 32'h700, 32'd1, 3'd0});
      req_q.push_back('{1'b1, 32'h800, 32'd1, 3'd0});
      client_set(1'b0, 1'b1, 32'h700, 32'd1, 3'd0);
      client_set(1'b1, 1'b1, 32'h800, 32'd1, 3'd0);
      rst = 1'b1;
      wait_grant(g, ok);
      total++;
      if (!ok || g != 0) $display("FAIL rst_tie: got c%0d, required c0", g);
      else pass++;
      tick();
      client_set(1'b0, 1'b0, 32'h700, 32'd1, 3'd0);
      dma_send(1'b0, 64'h30, 1, ok);
      wait_grant(g, ok);
      total++;
      if (!ok || g != 1) $display("FAIL rst_c1_grant: got c%0d, required c1", g);
      else pass++;
      tick();
      client_set(1'b1, 1'b0, 32'h800, 32'd1, 3'd0);
      dma_send(1'b1, 64'h31, 1, ok);
      total++;
      if (!ok || busy !== 1'b0) $display("FAIL rst_c1_done: got ok %b busy %b, required 1 0", ok, busy);
      else pass++;
   endtask

   initial begin
      client_set(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
      client_set(1'b1, 1'b0, 32'h0, 32'h0, 3'd0);
      bus.c0_rd_chnl_ready    = 1'b1;
      bus.c1_rd_chnl_ready    = 1'b1;
      bus.dma_read_ctrl_ready = 1'b1;
      bus.dma_read_chnl_valid = 1'b0;
      bus.dma_read_chnl_data  = '0;
      test_reset();
      test_round_robin();
      test_single();
      test_backpressure();
      test_zero_len();
      test_ctrl_stall();
      test_reset_mid_data();
      repeat (3) tick();
      total++;
      if (beat_q.size() != 0 || req_q.size() != 0)
         $display("FAIL scoreboard_drain: got %0d beats %0d reqs pending, required 0 0", beat_q.size(), req_q.size());
      else pass++;
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule

// File: doc/espacc_dma_rd_arbiter.md
# espacc_dma_rd_arbiter

Two-client arbiter that shares one ESP accelerator DMA read path, both the control channel and the read data channel, between two internal requesters. Typical requesters are an instruction fetcher and a data loader. It sits between the requesters and the 64-bit DMA read interface of a basic-DMA accelerator. Each grant covers one full transaction: the control handshake and then exactly `length` data beats. Grants alternate round-robin between the two clients.

## Interface
- `DMA_BUS_WIDTH`, 64: width of every read data bus.
- `LEN_WIDTH`, 32: width of the length field and the beat counter.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cN_rd_ctrl_valid`  in  1  client N (N=0,1) request valid.
- `cN_rd_ctrl_ready`  out  1  client N request accepted.
- `cN_rd_ctrl_index`  in  32  client N start word index.
- `cN_rd_ctrl_length`  in  32  client N beat count.
- `cN_rd_ctrl_size`  in  3  client N word size.
- `cN_rd_chnl_valid`  out  1  beat valid to client N.
- `cN_rd_chnl_ready`  in  1  client N beat ready.
- `cN_rd_chnl_data`  out  DMA_BUS_WIDTH  read data, broadcast to both clients.
- `dma_read_ctrl_valid`  out  1  request valid to the DMA.
- `dma_read_ctrl_ready`  in  1  DMA accepts the request.
- `dma_read_ctrl_data_index`  out  32  latched index.
- `dma_read_ctrl_data_length`  out  32  latched length.
- `dma_read_ctrl_data_size`  out  3  latched size.
- `dma_read_chnl_valid`  in  1  beat valid from the DMA.
- `dma_read_chnl_ready`  out  1  beat ready to the DMA.
- `dma_read_chnl_data`  in  DMA_BUS_WIDTH  beat data from the DMA.
- `busy`  out  1  high when the state is not IDLE.
- `owner`  out  1  index of the currently or most recently granted client.

## Operation
- The FSM has three states: IDLE, CTRL and DATA.
- **IDLE**
  - Winner when only one client is valid: that client.
  - Winner when both are valid: the client not equal to `rr_last`.
  - `cWINNER_rd_ctrl_ready` = 1, combinationally, in the same cycle.
  - On that handshake the arbiter latches index, length and size, sets `owner` = winner, sets `rr_last` = winner, and moves to CTRL.
- **CTRL**
  - `dma_read_ctrl_valid` = 1, with the latched fields driven on the data outputs.
  - On `dma_read_ctrl_ready`:
    - latched length = 0: go to IDLE with no data phase;
    - otherwise: load `beats_left` = length and go to DATA.
- **DATA**
  - `dma_read_chnl_ready` = `cOWNER_rd_chnl_ready`.
  - `cOWNER_rd_chnl_valid` = `dma_read_chnl_valid`; the other client's chnl_valid = 0.
  - Both paths are combinational.
  - Each beat handshake (DMA valid and ready both high) decrements `beats_left`.
  - The handshake that takes `beats_left` from 1 to 0 moves the FSM to IDLE.
- Outside DATA:
  - `dma_read_chnl_ready` = 0; DMA beats that arrive early are stalled, never dropped.
  - Both `cN_rd_chnl_valid` = 0.
- A client may deassert valid in IDLE before it is granted; the arbiter does not record a request.
- `cN_rd_chnl_data` = `dma_read_chnl_data` at all times.

## Timing
- **Reset** (`rst` = 0, asynchronous; takes effect immediately):
  - state = IDLE, `beats_left` = 0;
  - latched index, length and size = 0;
  - `owner` = 0, `rr_last` = 1, so client 0 wins the first tie.
  - All outputs read 0, including `dma_read_ctrl_valid`, both `cN_rd_ctrl_ready` and `busy`.
  - Reset asserted mid-transaction abandons the transaction. Any remaining DMA beats are the system's concern.
- **Request latency:**
  - client handshake in cycle T;
  - `dma_read_ctrl_valid` high from cycle T+1 and held until `dma_read_ctrl_ready`;
  - the latched fields stay stable while valid is high.
- **Data path:** zero-cycle pass-through in DATA; a beat can complete every cycle.
- **Release:** on the last beat in cycle T, the FSM is in IDLE at T+1 and can accept a new request at T+1. The minimum gap between consecutive DMA requests is 2 cycles.
- **Length-0 release:** the ctrl handshake at T returns the FSM to IDLE at T+1.
- **Full count:** `beats_left` is LEN_WIDTH bits wide and never wraps. Length 2^32-1 is legal.
- **Simultaneous events:**
  - a client requesting during CTRL or DATA sees ready = 0 until IDLE;
  - both clients valid in IDLE get tie-break by `rr_last` only.

## Test plan
- **Single client:** c0 requests index=0x100, length=4, size=3, and DMA ready is immediate.
  - c0_rd_ctrl_ready is high in cycle 0.
  - dma_read_ctrl_valid is high in cycle 1 with index 0x100 and length 4.
  - 4 beats pass to c0 and c1_rd_chnl_valid stays 0.
  - busy drops after the 4th beat.
- **Round-robin:** both clients hold valid continuously with length=2.
  - Grant order is c0, c1, c0, c1.
  - owner toggles after each transaction.
- **Backpressure:** in DATA, c1_rd_chnl_ready is low for 3 cycles while DMA valid is high.
  - dma_read_chnl_ready is 0 for those cycles.
  - beats_left is unchanged.
  - No data is lost; the data sequence 0xA..0xD arrives at c1 in order.
- **Zero length:** c0 requests length=0.
  - After the ctrl handshake the FSM returns to IDLE.
  - c0_rd_chnl_valid is never asserted.
  - An early DMA beat sees dma_read_chnl_ready = 0.
- **Reset mid-DATA:** assert rst low after 2 of 8 beats.
  - All outputs are 0 in the same cycle.
  - After release, a c1-only request is granted normally.
  - On a tie after reset, c0 wins.
- **Ctrl stall:** hold dma_read_ctrl_ready low for 5 cycles.
  - dma_read_ctrl_valid stays high with stable fields.
  - The other client's ctrl_ready stays 0 throughout.
